// File: rtl/count_serializer.sv
// UART-style serializer for the dual-counter byte: start, 8 data bits LSB first,
// optional even parity, stop; each bit held CLKS_PER_BIT clocks. Counts refused offers.
module count_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_nxt;
  logic [7:0] shreg;
  logic [7:0] timer;
  logic [2:0] bit_idx;
  logic       par;
  logic       bit_end;

  assign bit_end = (timer == LAST_TICK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    busy       = (state != IDLE);
    frame_done = (state == STOP) && bit_end;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      PARITY:  tx = par;
      default: tx = 1'b1;
    endcase
  end

  // The bit timer free-runs only while a frame is active; IDLE parks it at zero
  // so the start bit always gets a full CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      timer   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
    end else if (state == IDLE) begin
      timer   <= '0;
      bit_idx <= '0;
      if (in_valid) begin
        shreg <= in_data;
        par   <= ^in_data;
      end
    end else begin
      if (bit_end) timer <= '0;
      else         timer <= timer + 8'd1;
      if (state == DATA && bit_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         drop_cnt <= '0;
    else if (in_valid && !in_ready && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: doc/count_serializer.md
# count_serializer

Downstream consumer of the 8-bit dual-counter value ({count2, count1}). It accepts one byte per valid/ready handshake and transmits it on a single-wire, UART-style serial line:
- start bit, 8 data bits LSB first, optional even parity bit, stop bit;
- every bit held for a programmable number of clk cycles.

It also keeps a saturating count of samples offered while it was busy. This makes snapshots of the counter observable off-chip on one pin.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clk cycles per serial bit. Legal range 1..255.
- PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  8  byte to send (connects to the counter's out).
- in_valid  input  1  in_data is offered this cycle.
- in_ready  output  1  block is idle and accepts in_data this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress (inverse of in_ready).
- frame_done  output  1  one-cycle pulse in the last stop-bit cycle.
- drop_cnt  output  8  number of cycles in which in_valid=1 and in_ready=0; saturates at 0xFF.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered or decoded from registered state; there is no combinational path from in_* to tx.
- Reset values:
  - state IDLE;
  - tx=1, in_ready=1, busy=0, frame_done=0, drop_cnt=0x00;
  - shift register 0, bit-timer 0, bit-index 0.
- IDLE:
  - tx=1, in_ready=1.
  - On an edge with in_valid=1: latch in_data into the shift register, compute parity = XOR of the 8 bits, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift-register bit 0; shift right every CLKS_PER_BIT cycles.
  - After 8 bits, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx = latched parity bit (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 during the final cycle. Then go to IDLE.
- The bit-timer counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. With CLKS_PER_BIT=1, every cycle is a new bit.
- in_data is sampled only at acceptance. Changes to in_data mid-frame do not affect the frame in progress.
- drop_cnt:
  - increments on every edge where in_valid=1 and in_ready=0;
  - holds at 0xFF;
  - is cleared only by rst.
- Reset mid-frame: rst is asynchronous, so tx goes to 1 and the FSM to IDLE immediately. The partial frame is abandoned and never resumed.

## Timing
- Let C = CLKS_PER_BIT and N = 10 + PARITY_EN. Acceptance happens at edge E0. Cycle k is the cycle after edge E0+k-1.
- Start bit: cycles 1..C.
- Data bit i (i = 0..7): cycles C(i+1)+1 .. C(i+2).
- Parity bit (when enabled): cycles 9C+1 .. 10C.
- Stop bit: cycles (N-1)C+1 .. NC. frame_done is high in cycle NC.
- in_ready returns to 1 in cycle NC+1. The earliest next acceptance is the edge ending that cycle. Back-to-back frames are therefore separated by exactly one idle cycle with tx=1.
- Frame period with continuous in_valid: N·C + 1 cycles (45 for the default parameters).
- busy = ~in_ready at all times.

## Test plan
- Basic frame: C=4, PARITY_EN=1. Reset, then present in_data=0xA5 with in_valid=1 for one cycle.
  - Required bit sequence on tx, each bit for 4 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - frame_done pulses exactly in cycle 44; in_ready is 1 in cycle 45.
- Parity values:
  - 0x01 gives parity bit 1.
  - 0xFF gives parity bit 0.
  - With PARITY_EN=0, 0xFF produces a 40-cycle frame with no parity bit; frame_done is in cycle 40.
- Back-to-back / drop counting:
  - Drive the counter's out with in_valid held high from reset release.
  - Consecutive start bits are exactly 45 cycles apart.
  - drop_cnt after the first complete frame is 44.
  - Transmitted bytes equal the counter values sampled at each acceptance edge.
- Saturation: hold in_valid=1 for 400 cycles with C=4. drop_cnt reaches 0xFF and stays there; it never wraps to 0x00.
- Reset mid-operation: assert rst during data bit 3 of a frame.
  - tx=1, in_ready=1, drop_cnt=0 immediately, without waiting for a clock edge.
  - After release, a new 0x3C frame transmits correctly.
- C=1 corner: send 0x80. tx is 0,0,0,0,0,0,0,0,1, parity 1, stop 1, one cycle each; frame_done is in cycle 11.
